// File: rtl/cfu_mac_multi_acc.sv
// Custom-function unit: int8 4-lane dot-product MAC into NUM_ACC selectable 32-bit accumulators,
// with input offset, bias load, read, clear and read-clear ops over a valid/ready command/response pair.
module cfu_mac_multi_acc #(
  parameter int NUM_ACC   = 4,
  parameter int PIPELINED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 8;
  localparam int OFF_W  = 9;
  localparam int IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  localparam logic [2:0] OP_MAC        = 3'd0;
  localparam logic [2:0] OP_SET_OFFSET = 3'd1;
  localparam logic [2:0] OP_LOAD       = 3'd2;
  localparam logic [2:0] OP_READ       = 3'd3;
  localparam logic [2:0] OP_CLEAR_ALL  = 3'd4;
  localparam logic [2:0] OP_READ_CLEAR = 3'd5;

  // Sum of the four (activation + offset) * weight lane products; every lane fits 17 bits.
  function automatic logic signed [DATA_W-1:0] dot4(
    input logic [DATA_W-1:0]       act,
    input logic [DATA_W-1:0]       wgt,
    input logic signed [OFF_W-1:0] off
  );
    logic signed [DATA_W-1:0] sum;
    logic signed [DATA_W-1:0] xa;
    logic signed [DATA_W-1:0] xw;
    logic signed [DATA_W-1:0] xo;
    sum = '0;
    xo  = {{(DATA_W-OFF_W){off[OFF_W-1]}}, off};
    for (int i = 0; i < 4; i++) begin
      xa  = {{(DATA_W-COEF_W){act[COEF_W*i+COEF_W-1]}}, act[COEF_W*i +: COEF_W]};
      xw  = {{(DATA_W-COEF_W){wgt[COEF_W*i+COEF_W-1]}}, wgt[COEF_W*i +: COEF_W]};
      sum = sum + (xa + xo) * xw;
    end
    return sum;
  endfunction

  function automatic logic [DATA_W-1:0] sext_off(input logic signed [OFF_W-1:0] off);
    return {{(DATA_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

  logic                     accept;
  logic                     busy;
  logic signed [OFF_W-1:0]  offset;
  logic signed [DATA_W-1:0] acc [NUM_ACC];

  // Stage 0: decode the command as presented.
  logic [2:0]               op_p0;
  logic [6:0]               sel_p0;
  logic [IDX_W-1:0]         idx_p0;
  logic signed [DATA_W-1:0] lane_p0;
  logic                     unused_sel;

  assign op_p0      = cmd_payload_function_id[2:0];
  assign sel_p0     = cmd_payload_function_id[9:3];
  assign idx_p0     = (NUM_ACC == 1) ? '0 : IDX_W'(sel_p0);
  assign unused_sel = ^sel_p0;
  assign lane_p0    = dot4(cmd_payload_inputs_0, cmd_payload_inputs_1, offset);

  assign cmd_ready = !reset && !busy && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;

  logic                     exec_vld;
  logic [2:0]               exec_op;
  logic [IDX_W-1:0]         exec_idx;
  logic [DATA_W-1:0]        exec_in0;
  logic signed [DATA_W-1:0] exec_lane;

  generate
    if (PIPELINED != 0) begin : g_pipe
      // Stage 1: products captured at acceptance with the offset in effect then.
      logic                     vld_p1;
      logic [2:0]               op_p1;
      logic [IDX_W-1:0]         idx_p1;
      logic [DATA_W-1:0]        in0_p1;
      logic signed [DATA_W-1:0] lane_p1;

      always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= accept;
      end

      always_ff @(posedge clk) begin
        if (accept) begin
          op_p1   <= op_p0;
          idx_p1  <= idx_p0;
          in0_p1  <= cmd_payload_inputs_0;
          lane_p1 <= lane_p0;
        end
      end

      assign busy      = vld_p1;
      assign exec_vld  = vld_p1;
      assign exec_op   = op_p1;
      assign exec_idx  = idx_p1;
      assign exec_in0  = in0_p1;
      assign exec_lane = lane_p1;
    end else begin : g_flat
      assign busy      = 1'b0;
      assign exec_vld  = accept;
      assign exec_op   = op_p0;
      assign exec_idx  = idx_p0;
      assign exec_in0  = cmd_payload_inputs_0;
      assign exec_lane = lane_p0;
    end
  endgenerate

  // Stage 2: state update and response register; payload holds until the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      offset                <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (exec_vld) begin
      rsp_valid <= 1'b1;
      case (exec_op)
        OP_MAC: begin
          acc[exec_idx]         <= acc[exec_idx] + exec_lane;
          rsp_payload_outputs_0 <= acc[exec_idx] + exec_lane;
        end
        OP_SET_OFFSET: begin
          offset                <= exec_in0[OFF_W-1:0];
          rsp_payload_outputs_0 <= sext_off(exec_in0[OFF_W-1:0]);
        end
        OP_LOAD: begin
          acc[exec_idx]         <= exec_in0;
          rsp_payload_outputs_0 <= exec_in0;
        end
        OP_READ: begin
          rsp_payload_outputs_0 <= acc[exec_idx];
        end
        OP_CLEAR_ALL: begin
          for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
          rsp_payload_outputs_0 <= '0;
        end
        OP_READ_CLEAR: begin
          acc[exec_idx]         <= '0;
          rsp_payload_outputs_0 <= acc[exec_idx];
        end
        default: begin
          rsp_payload_outputs_0 <= '0;
        end
      endcase
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfu_mac_multi_acc.sv
// Directed bench for cfu_mac_multi_acc: reference model feeds an expected-response queue,
// responses are popped and checked with immediate assertions.
module tb_cfu_mac_multi_acc;

  localparam int PIPE = 1;
  localparam int LAT  = (PIPE != 0) ? 2 : 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_acc [4];
  int          m_off;

  always #5 clk = ~clk;

  cfu_mac_multi_acc #(.NUM_ACC(4), .PIPELINED(PIPE)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = '0;
    m_off = 0;
  endfunction

  function automatic logic [31:0] model_step(input logic [2:0] op, input logic [6:0] sel,
                                             input logic [31:0] in0, input logic [31:0] in1);
    int          idx;
    int          sum;
    int          a;
    int          b;
    logic [31:0] r;
    logic [7:0]  ba;
    logic [7:0]  bb;
    logic [8:0]  o9;
    idx = int'(sel) % 4;
    r   = '0;
    case (op)
      3'd0: begin
        sum = 0;
        for (int i = 0; i < 4; i++) begin
          ba  = in0[8*i +: 8];
          bb  = in1[8*i +: 8];
          a   = $signed(ba);
          b   = $signed(bb);
          sum = sum + (a + m_off) * b;
        end
        m_acc[idx] = m_acc[idx] + 32'(sum);
        r = m_acc[idx];
      end
      3'd1: begin
        o9    = in0[8:0];
        m_off = $signed(o9);
        r     = 32'(m_off);
      end
      3'd2: begin m_acc[idx] = in0; r = in0; end
      3'd3: r = m_acc[idx];
      3'd4: begin for (int i = 0; i < 4; i++) m_acc[i] = '0; r = '0; end
      3'd5: begin r = m_acc[idx]; m_acc[idx] = '0; end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("rsp_latency", 32'(lat), 32'(LAT));
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [6:0] sel,
                        input logic [31:0] in0, input logic [31:0] in1);
    int          lat;
    logic [31:0] exp;
    exp_q.push_back(model_step(op, sel, in0, in1));
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {sel, op};
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    exp = exp_q.pop_front();
    check(tag, rsp_payload_outputs_0, exp);
    @(posedge clk); #1;
    check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check("ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] exp;

    reset                   = 1'b1;
    cmd_valid               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    rsp_ready               = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_payload", rsp_payload_outputs_0, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Reference vectors with fixed answers.
    do_cmd("set_off_128", 3'd1, 7'd0, 32'h0000_0080, 32'h0);
    do_cmd("mac_522", 3'd0, 7'd0, 32'h0102_0304, 32'h0101_0101);
    check("mac_522_const", m_acc[0], 32'h0000_020A);
    do_cmd("mac_zero", 3'd0, 7'd1, 32'h8080_8080, 32'h7F7F_7F7F);
    do_cmd("read_acc1", 3'd3, 7'd1, 32'h0, 32'h0);
    do_cmd("read_acc0", 3'd3, 7'd0, 32'h0, 32'h0);
    check("acc0_const", m_acc[0], 32'd522);
    do_cmd("load_max", 3'd2, 7'd2, 32'h7FFF_FFFF, 32'h0);
    do_cmd("set_off_0", 3'd1, 7'd0, 32'h0, 32'h0);
    do_cmd("mac_wrap", 3'd0, 7'd2, 32'h0000_0001, 32'h0000_0001);
    check("wrap_const", m_acc[2], 32'h8000_0000);

    // Index aliasing and read-clear.
    do_cmd("load_sel6", 3'd2, 7'd6, 32'd5, 32'h0);
    do_cmd("read_clear", 3'd5, 7'd2, 32'h0, 32'h0);
    do_cmd("read_cleared", 3'd3, 7'd2, 32'h0, 32'h0);
    do_cmd("alias_sel126", 3'd3, 7'd126, 32'h0, 32'h0);

    // Negative offset and mixed-sign lanes.
    do_cmd("set_off_m1", 3'd1, 7'd0, 32'hABCD_E1FF, 32'h0);
    do_cmd("mac_mixed", 3'd0, 7'd3, 32'h80FF_7F00, 32'h8081_7F02);
    for (int k = 0; k < 4; k++) begin
      do_cmd("set_off_rand", 3'd1, 7'($urandom_range(0, 127)), $urandom, $urandom);
      do_cmd("mac_rand", 3'd0, 7'($urandom_range(0, 127)), $urandom, $urandom);
      do_cmd("read_rand", 3'd3, 7'($urandom_range(0, 127)), $urandom, $urandom);
    end

    // Reserved ops, clear-all, offset survives clear.
    do_cmd("op6", 3'd6, 7'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_cmd("op7", 3'd7, 7'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_cmd("set_off_m1b", 3'd1, 7'd0, 32'h0000_01FF, 32'h0);
    do_cmd("clear_all", 3'd4, 7'd0, 32'h1234_5678, 32'h0);
    do_cmd("read0_clr", 3'd3, 7'd0, 32'h0, 32'h0);
    do_cmd("read3_clr", 3'd3, 7'd3, 32'h0, 32'h0);
    do_cmd("mac_off_kept", 3'd0, 7'd0, 32'h0, 32'h0000_0001);
    check("off_kept_const", m_acc[0], 32'hFFFF_FFFF);

    // Response backpressure with an ignored command presented meanwhile.
    rsp_ready = 1'b0;
    exp_q.push_back(model_step(3'd3, 7'd0, 32'h0, 32'h0));
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd0, 3'd3};
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    exp = exp_q.pop_front();
    check("bp_rsp", rsp_payload_outputs_0, exp);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd0, 3'd2};
    cmd_payload_inputs_0    = 32'h0000_1234;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      check("bp_payload_hold", rsp_payload_outputs_0, exp);
      check("bp_not_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_single_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("bp_no_second", {31'd0, rsp_valid}, 32'd0);
    do_cmd("bp_load_ignored", 3'd3, 7'd0, 32'h0, 32'h0);

    // Reset one cycle after a MAC is accepted drops it.
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd0, 3'd0};
    cmd_payload_inputs_0    = 32'h0000_0001;
    cmd_payload_inputs_1    = 32'h0000_0001;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_cmd("read0_after_rst", 3'd3, 7'd0, 32'h0, 32'h0);
    do_cmd("mac_after_rst", 3'd0, 7'd1, 32'h0102_0304, 32'h0101_0101);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
